// File: rtl/apb2axi_read_collector_if.sv
// Signal bundle between the AXI R channel, the issue directory, the RDF and the completion FIFO.
// The master modport is the collector's view; the slave modport is the surrounding environment.
interface apb2axi_read_collector_if #(
    parameter int TAG_NUM    = 4,
    parameter int AXI_ID_W   = 4,
    parameter int AXI_DATA_W = 64
);
    localparam int TAG_W = (TAG_NUM > 1) ? $clog2(TAG_NUM) : 1;

    typedef struct packed {
        logic [TAG_W-1:0]      tag;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } rdf_entry_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [1:0]       resp;
        logic             err;
    } completion_entry_t;

    logic                  dir_rc_issue_vld;
    logic [TAG_W-1:0]      dir_rc_issue_tag;
    logic [7:0]            dir_rc_issue_len;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;
    logic [AXI_ID_W-1:0]   m_axi_rid;
    logic [AXI_DATA_W-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  rdf_push_vld;
    rdf_entry_t            rdf_push_payload;
    logic                  rdf_push_rdy;
    logic                  cq_push_vld;
    completion_entry_t     cq_push_data;
    logic                  cq_push_rdy;
    logic                  rc_err_unexp;
    logic [TAG_NUM-1:0]    rc_active;

    modport master (
        input  dir_rc_issue_vld, dir_rc_issue_tag, dir_rc_issue_len,
        input  m_axi_rvalid, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
        output m_axi_rready,
        output rdf_push_vld, rdf_push_payload,
        input  rdf_push_rdy,
        output cq_push_vld, cq_push_data,
        input  cq_push_rdy,
        output rc_err_unexp, rc_active
    );

    modport slave (
        output dir_rc_issue_vld, dir_rc_issue_tag, dir_rc_issue_len,
        output m_axi_rvalid, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
        input  m_axi_rready,
        input  rdf_push_vld, rdf_push_payload,
        output rdf_push_rdy,
        input  cq_push_vld, cq_push_data,
        output cq_push_rdy,
        input  rc_err_unexp, rc_active
    );
endinterface

// File: rtl/apb2axi_read_collector.sv
// Collects AXI R beats per tag, forwards them into the RDF and queues one completion per finished read.
// Both output stages are registered; R is back-pressured whenever either stage could not take a beat.
module apb2axi_read_collector #(
    parameter int TAG_NUM    = 4,
    parameter int AXI_ID_W   = 4,
    parameter int AXI_DATA_W = 64,
    parameter int CPL_DEPTH  = 4
) (
    input logic pclk,
    input logic preset,
    apb2axi_read_collector_if.master bus
);
    localparam int TAG_W = (TAG_NUM > 1) ? $clog2(TAG_NUM) : 1;
    localparam int CQ_AW = (CPL_DEPTH > 1) ? $clog2(CPL_DEPTH) : 1;
    localparam logic [CQ_AW:0]    CQ_FULL   = (CQ_AW + 1)'(CPL_DEPTH);
    localparam logic [CQ_AW:0]    CNT_ONE   = (CQ_AW + 1)'(1);
    localparam logic [CQ_AW-1:0]  PTR_ONE   = CQ_AW'(1);
    localparam logic [AXI_ID_W:0] TAG_LIMIT = (AXI_ID_W + 1)'(TAG_NUM);

    logic [TAG_NUM-1:0] active;
    logic [7:0]         len_q [TAG_NUM];
    logic [7:0]         cnt_q [TAG_NUM];
    logic [1:0]         acc_q [TAG_NUM];

    logic                  rdf_vld;
    logic [TAG_W-1:0]      rdf_tag;
    logic [AXI_DATA_W-1:0] rdf_data;
    logic [1:0]            rdf_resp;
    logic                  rdf_last;
    logic                  unexp_q;

    logic [TAG_W+2:0] cq_mem [CPL_DEPTH];
    logic [CQ_AW-1:0] wr_ptr;
    logic [CQ_AW-1:0] rd_ptr;
    logic [CQ_AW:0]   cq_count;

    logic [TAG_W-1:0] rtag;
    logic [TAG_W-1:0] itag;
    logic             rready;
    logic             beat;
    logic             tag_ok;
    logic             hit;
    logic             final_beat;
    logic             closing;
    logic             beat_err;
    logic             issue_ok;
    logic             cq_push;
    logic             cq_pop;
    logic [1:0]       new_resp;

    assign rtag   = bus.m_axi_rid[TAG_W-1:0];
    assign itag   = bus.dir_rc_issue_tag;
    // Conservative ready: never looks at rlast, so a full completion queue stalls every beat.
    assign rready = (!rdf_vld || bus.rdf_push_rdy) && (cq_count != CQ_FULL) && !preset;
    assign beat   = bus.m_axi_rvalid && rready;
    assign tag_ok = {1'b0, bus.m_axi_rid} < TAG_LIMIT;
    assign cq_push = closing;
    assign cq_pop  = (cq_count != '0) && bus.cq_push_rdy;

    always_comb begin
        hit        = beat && tag_ok && active[rtag];
        final_beat = cnt_q[rtag] == len_q[rtag];
        closing    = hit && (final_beat || bus.m_axi_rlast);
        beat_err   = bus.m_axi_rlast != final_beat;
        new_resp   = (bus.m_axi_rresp > acc_q[rtag]) ? bus.m_axi_rresp : acc_q[rtag];
        // A tag closing this cycle may be re-issued at once; the new read starts next cycle.
        issue_ok   = bus.dir_rc_issue_vld && (!active[itag] || (closing && rtag == itag));
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            active <= '0;
            for (int i = 0; i < TAG_NUM; i++) begin
                len_q[i] <= '0;
                cnt_q[i] <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TAG_NUM; i++) begin
                if (hit && rtag == TAG_W'(i)) begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                    acc_q[i] <= new_resp;
                    if (closing) begin
                        active[i] <= 1'b0;
                    end
                end
                if (issue_ok && itag == TAG_W'(i)) begin
                    active[i] <= 1'b1;
                    len_q[i]  <= bus.dir_rc_issue_len;
                    cnt_q[i]  <= '0;
                    acc_q[i]  <= '0;
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            rdf_vld  <= 1'b0;
            rdf_tag  <= '0;
            rdf_data <= '0;
            rdf_resp <= '0;
            rdf_last <= 1'b0;
            unexp_q  <= 1'b0;
        end else begin
            unexp_q <= beat && !hit;
            if (hit) begin
                rdf_vld  <= 1'b1;
                rdf_tag  <= rtag;
                rdf_data <= bus.m_axi_rdata;
                rdf_resp <= bus.m_axi_rresp;
                rdf_last <= final_beat || bus.m_axi_rlast;
            end else if (bus.rdf_push_rdy) begin
                rdf_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cq_count <= '0;
        end else begin
            if (cq_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (cq_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (cq_push && !cq_pop) begin
                cq_count <= cq_count + CNT_ONE;
            end else if (!cq_push && cq_pop) begin
                cq_count <= cq_count - CNT_ONE;
            end
        end
    end

    // Entry storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge pclk) begin
        if (cq_push) begin
            cq_mem[wr_ptr] <= {rtag, new_resp, beat_err};
        end
    end

    assign bus.m_axi_rready     = rready;
    assign bus.rdf_push_vld     = rdf_vld;
    assign bus.rdf_push_payload = {rdf_tag, rdf_data, rdf_resp, rdf_last};
    assign bus.cq_push_vld      = cq_count != '0;
    assign bus.cq_push_data     = (cq_count != '0) ? cq_mem[rd_ptr] : '0;
    assign bus.rc_err_unexp     = unexp_q;
    assign bus.rc_active        = active;
endmodule

// File: tb/tb_apb2axi_read_collector.sv
// Bench for apb2axi_read_collector: directed scenarios with literal expectations plus a randomized
// phase, all outputs compared every cycle against a transaction-level model of tags and queues.
module tb_apb2axi_read_collector;
    localparam int TAG_NUM    = 4;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_DATA_W = 64;
    localparam int CPL_DEPTH  = 4;

    typedef struct {
        int tag;
        int resp;
        int err;
    } cpl_t;

    logic pclk = 1'b0;
    logic preset;
    int   checks = 0;
    int   errors = 0;

    apb2axi_read_collector_if #(.TAG_NUM(TAG_NUM), .AXI_ID_W(AXI_ID_W), .AXI_DATA_W(AXI_DATA_W)) bus ();

    apb2axi_read_collector #(
        .TAG_NUM(TAG_NUM), .AXI_ID_W(AXI_ID_W), .AXI_DATA_W(AXI_DATA_W), .CPL_DEPTH(CPL_DEPTH)
    ) dut (
        .pclk(pclk),
        .preset(preset),
        .bus(bus)
    );

    always #5 pclk = ~pclk;

    // Model state: per-tag read bookkeeping, the RDF register and the completion queue.
    bit          m_act [TAG_NUM];
    int          m_len [TAG_NUM];
    int          m_cnt [TAG_NUM];
    int          m_acc [TAG_NUM];
    bit          e_rdf_vld = 0;
    int          e_tag = 0;
    logic [63:0] e_data = '0;
    int          e_resp = 0;
    bit          e_last = 0;
    bit          e_unexp = 0;
    cpl_t        e_cq[$];

    logic [68:0] rdf_log[$];
    logic [4:0]  cq_log[$];
    int          unexp_seen = 0;

    function automatic void check_output(string name, logic [63:0] actual, logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endfunction

    // Outputs are compared at the falling edge, then the model advances to what the next rising edge must produce.
    always @(negedge pclk) begin : model
        bit       rr;
        int       t;
        bit       fin;
        bit       close;
        logic [3:0] ea;
        cpl_t     c;

        rr = !preset && (!e_rdf_vld || bus.rdf_push_rdy) && (e_cq.size() < CPL_DEPTH);
        for (int i = 0; i < TAG_NUM; i++) ea[i] = m_act[i];
        check_output("rready", bus.m_axi_rready, rr);
        check_output("rdf_vld", bus.rdf_push_vld, e_rdf_vld);
        if (e_rdf_vld) begin
            check_output("rdf_tag", bus.rdf_push_payload.tag, e_tag);
            check_output("rdf_data", bus.rdf_push_payload.data, e_data);
            check_output("rdf_resp", bus.rdf_push_payload.resp, e_resp);
            check_output("rdf_last", bus.rdf_push_payload.last, e_last);
        end
        check_output("cq_vld", bus.cq_push_vld, e_cq.size() > 0);
        if (e_cq.size() > 0) begin
            check_output("cq_tag", bus.cq_push_data.tag, e_cq[0].tag);
            check_output("cq_resp", bus.cq_push_data.resp, e_cq[0].resp);
            check_output("cq_err", bus.cq_push_data.err, e_cq[0].err);
        end
        check_output("err_unexp", bus.rc_err_unexp, e_unexp);
        check_output("rc_active", bus.rc_active, ea);

        if (bus.rdf_push_vld && bus.rdf_push_rdy) rdf_log.push_back(bus.rdf_push_payload);
        if (bus.cq_push_vld && bus.cq_push_rdy) cq_log.push_back(bus.cq_push_data);
        if (bus.rc_err_unexp) unexp_seen++;

        if (preset) begin
            for (int i = 0; i < TAG_NUM; i++) begin
                m_act[i] = 0; m_len[i] = 0; m_cnt[i] = 0; m_acc[i] = 0;
            end
            e_rdf_vld = 0; e_tag = 0; e_data = '0; e_resp = 0; e_last = 0; e_unexp = 0;
            e_cq.delete();
        end else begin
            if (e_rdf_vld && bus.rdf_push_rdy) e_rdf_vld = 0;
            if (e_cq.size() > 0 && bus.cq_push_rdy) void'(e_cq.pop_front());
            e_unexp = 0;
            if (bus.m_axi_rvalid && rr) begin
                t = int'(bus.m_axi_rid);
                if (t < TAG_NUM && m_act[t]) begin
                    fin   = (m_cnt[t] == m_len[t]);
                    close = fin || bus.m_axi_rlast;
                    if (int'(bus.m_axi_rresp) > m_acc[t]) m_acc[t] = int'(bus.m_axi_rresp);
                    m_cnt[t]++;
                    e_rdf_vld = 1; e_tag = t; e_data = bus.m_axi_rdata;
                    e_resp = int'(bus.m_axi_rresp); e_last = close;
                    if (close) begin
                        m_act[t] = 0;
                        c.tag = t; c.resp = m_acc[t]; c.err = (bus.m_axi_rlast != fin);
                        e_cq.push_back(c);
                    end
                end else begin
                    e_unexp = 1;
                end
            end
            if (bus.dir_rc_issue_vld && !m_act[int'(bus.dir_rc_issue_tag)]) begin
                t = int'(bus.dir_rc_issue_tag);
                m_act[t] = 1; m_len[t] = int'(bus.dir_rc_issue_len); m_cnt[t] = 0; m_acc[t] = 0;
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic apply_issue(input int tag, input int len);
        bus.dir_rc_issue_vld = 1'b1;
        bus.dir_rc_issue_tag = 2'(tag);
        bus.dir_rc_issue_len = 8'(len);
        tick();
        bus.dir_rc_issue_vld = 1'b0;
    endtask

    task automatic apply_stimulus(input int id, input logic [63:0] data, input int resp, input bit last);
        int n = 0;
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rid    = 4'(id);
        bus.m_axi_rdata  = data;
        bus.m_axi_rresp  = 2'(resp);
        bus.m_axi_rlast  = last;
        forever begin
            @(negedge pclk);
            if (bus.m_axi_rready === 1'b1) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("[TB] FAIL beat_timeout actual=stalled required=accepted id=%0d", id);
                break;
            end
        end
        tick();
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
    endtask

    task automatic clear_logs();
        rdf_log.delete();
        cq_log.delete();
    endtask

    initial begin
        int unexp_before;
        int rid;
        preset = 1'b1;
        bus.dir_rc_issue_vld = 1'b0; bus.dir_rc_issue_tag = '0; bus.dir_rc_issue_len = '0;
        bus.m_axi_rvalid = 1'b0; bus.m_axi_rid = '0; bus.m_axi_rdata = '0;
        bus.m_axi_rresp = '0; bus.m_axi_rlast = 1'b0;
        bus.rdf_push_rdy = 1'b1; bus.cq_push_rdy = 1'b1;
        repeat (2) tick();
        check_output("reset_rready", bus.m_axi_rready, 0);
        check_output("reset_rdf_vld", bus.rdf_push_vld, 0);
        check_output("reset_cq_vld", bus.cq_push_vld, 0);
        check_output("reset_active", bus.rc_active, 0);
        preset = 1'b0;
        tick();

        // Single 4-beat read on tag 2.
        clear_logs();
        apply_issue(2, 3);
        check_output("s1_active_set", bus.rc_active[2], 1);
        for (int i = 0; i < 4; i++) apply_stimulus(2, 64'hA0 + 64'(i), 0, i == 3);
        repeat (3) tick();
        check_output("s1_rdf_count", rdf_log.size(), 4);
        for (int i = 0; i < rdf_log.size() && i < 4; i++) begin
            check_output("s1_rdf_tag", rdf_log[i][68:67], 2);
            check_output("s1_rdf_data", rdf_log[i][66:3], 64'hA0 + 64'(i));
            check_output("s1_rdf_last", rdf_log[i][0], i == 3);
        end
        check_output("s1_cq_count", cq_log.size(), 1);
        if (cq_log.size() > 0) check_output("s1_cq_entry", cq_log[0], {2'd2, 2'd0, 1'b0});
        check_output("s1_active_clr", bus.rc_active[2], 0);

        // Interleaved tags 0 and 1 with response accumulation.
        clear_logs();
        apply_issue(0, 1);
        apply_issue(1, 1);
        apply_stimulus(0, 64'hB0, 0, 0);
        apply_stimulus(1, 64'hB1, 2, 0);
        apply_stimulus(1, 64'hB2, 0, 1);
        apply_stimulus(0, 64'hB3, 3, 1);
        repeat (3) tick();
        check_output("s2_cq_count", cq_log.size(), 2);
        if (cq_log.size() > 1) begin
            check_output("s2_cq_first", cq_log[0], {2'd1, 2'd2, 1'b0});
            check_output("s2_cq_second", cq_log[1], {2'd0, 2'd3, 1'b0});
        end

        // Early RLAST on tag 3, then a stray beat for the now-inactive tag.
        clear_logs();
        unexp_before = unexp_seen;
        apply_issue(3, 3);
        apply_stimulus(3, 64'hC0, 0, 0);
        apply_stimulus(3, 64'hC1, 0, 1);
        apply_stimulus(3, 64'hC2, 0, 0);
        repeat (3) tick();
        check_output("s3_rdf_count", rdf_log.size(), 2);
        if (rdf_log.size() > 1) check_output("s3_rdf_last", rdf_log[1][0], 1);
        check_output("s3_cq_count", cq_log.size(), 1);
        if (cq_log.size() > 0) check_output("s3_cq_entry", cq_log[0], {2'd3, 2'd0, 1'b1});
        check_output("s3_unexp", unexp_seen - unexp_before, 1);

        // Missing RLAST on a single-beat read.
        clear_logs();
        apply_issue(1, 0);
        apply_stimulus(1, 64'hC8, 0, 0);
        repeat (3) tick();
        check_output("s4_rdf_count", rdf_log.size(), 1);
        if (rdf_log.size() > 0) check_output("s4_rdf_last", rdf_log[0][0], 1);
        if (cq_log.size() > 0) check_output("s4_cq_entry", cq_log[0], {2'd1, 2'd0, 1'b1});
        else check_output("s4_cq_count", cq_log.size(), 1);

        // RDF back-pressure: hold, then release.
        clear_logs();
        apply_issue(2, 1);
        bus.rdf_push_rdy = 1'b0;
        apply_stimulus(2, 64'hD0, 1, 0);
        repeat (3) begin
            @(negedge pclk);
            check_output("s5_hold_rready", bus.m_axi_rready, 0);
            check_output("s5_hold_data", bus.rdf_push_payload.data, 64'hD0);
        end
        tick();
        bus.rdf_push_rdy = 1'b1;
        @(negedge pclk);
        check_output("s5_release_rready", bus.m_axi_rready, 1);
        tick();
        apply_stimulus(2, 64'hD1, 0, 1);
        repeat (3) tick();
        if (cq_log.size() > 0) check_output("s5_cq_entry", cq_log[0], {2'd2, 2'd1, 1'b0});
        else check_output("s5_cq_count", cq_log.size(), 1);

        // Fill the completion queue, then reset mid-burst.
        bus.cq_push_rdy = 1'b0;
        for (int t = 0; t < 4; t++) begin
            apply_issue(t, 0);
            apply_stimulus(t, 64'hE0 + 64'(t), 0, 1);
        end
        @(negedge pclk);
        check_output("s6_full_rready", bus.m_axi_rready, 0);
        check_output("s6_full_cq_vld", bus.cq_push_vld, 1);
        tick();
        apply_issue(0, 3);
        bus.m_axi_rvalid = 1'b1; bus.m_axi_rid = 4'd0; bus.m_axi_rdata = 64'hF0;
        preset = 1'b1;
        tick();
        check_output("s6_rst_rready", bus.m_axi_rready, 0);
        check_output("s6_rst_rdf_vld", bus.rdf_push_vld, 0);
        check_output("s6_rst_cq_vld", bus.cq_push_vld, 0);
        check_output("s6_rst_active", bus.rc_active, 0);
        check_output("s6_rst_unexp", bus.rc_err_unexp, 0);
        preset = 1'b0;
        bus.m_axi_rvalid = 1'b0;
        bus.cq_push_rdy = 1'b1;
        @(negedge pclk);
        check_output("s6_after_cq_vld", bus.cq_push_vld, 0);
        check_output("s6_after_rready", bus.m_axi_rready, 1);
        tick();

        // Randomized traffic, checked cycle by cycle by the model.
        for (int cyc = 0; cyc < 800; cyc++) begin
            preset = ($urandom_range(0, 199) == 0);
            bus.dir_rc_issue_vld = ($urandom_range(0, 3) == 0);
            bus.dir_rc_issue_tag = 2'($urandom_range(0, 3));
            bus.dir_rc_issue_len = 8'($urandom_range(0, 3));
            rid = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
            bus.m_axi_rvalid = $urandom_range(0, 1) == 1;
            bus.m_axi_rid    = 4'(rid);
            bus.m_axi_rdata  = {$urandom, $urandom};
            bus.m_axi_rresp  = 2'($urandom_range(0, 3));
            if (rid < TAG_NUM && m_act[rid])
                bus.m_axi_rlast = (m_cnt[rid] == m_len[rid]) ^ ($urandom_range(0, 7) == 0);
            else
                bus.m_axi_rlast = $urandom_range(0, 1) == 1;
            bus.rdf_push_rdy = ($urandom_range(0, 3) != 0);
            bus.cq_push_rdy  = ($urandom_range(0, 2) != 0);
            tick();
        end

        preset = 1'b0;
        bus.dir_rc_issue_vld = 1'b0;
        bus.m_axi_rvalid = 1'b0;
        bus.rdf_push_rdy = 1'b1;
        bus.cq_push_rdy = 1'b1;
        repeat (8) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
